// File: rtl/mem_bank_pkg.sv
// Shared definitions for the memory bank controller: default widths, op encoding, FSM states.
package mem_bank_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 3;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage : mem_bank_pkg

// File: rtl/mem_bank_ctrl.sv
// Single-outstanding request/response controller for a synchronous 8-entry bank.
// Optional saturating error counter output err_cnt when MEM_BANK_CTRL_ERR_CNT_EN is defined.
module mem_bank_ctrl
   import mem_bank_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [DATA_W-1:0] bank_din,
   output logic [ADDR_W-1:0] bank_addr,
   output logic              bank_wr,
   output logic              bank_rd,
   input  logic [DATA_W-1:0] bank_dout,
   input  logic              bank_error
`ifdef MEM_BANK_CTRL_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   state_t              state_q, state_d;
   logic                op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;

   logic                req_ready_d;
   logic                rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_d;
   logic                rsp_err_d;
   logic                bank_rd_d;
   logic                bank_wr_d;
   logic [ADDR_W-1:0]   bank_addr_d;
   logic [DATA_W-1:0]   bank_din_d;

   // Next state, capture, and next values of every (registered) output
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rsp_data_d = rsp_data;
      rsp_err_d  = rsp_err;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d = ISSUE;
               op_d    = req_op;
               addr_d  = req_addr;
               data_d  = req_data;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // Bank answers one cycle after the strobe; an error overrides read data
            state_d    = RESP;
            rsp_err_d  = bank_error;
            rsp_data_d = (op_q == OP_RD && !bank_error) ? bank_dout : '0;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d    = IDLE;
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      bank_rd_d   = (state_d == ISSUE) && (op_d == OP_RD);
      bank_wr_d   = (state_d == ISSUE) && (op_d == OP_WR);
      bank_addr_d = (state_d == IDLE) ? '0 : addr_d;
      bank_din_d  = (state_d == IDLE) ? '0 : data_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= OP_RD;
         addr_q    <= '0;
         data_q    <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         bank_rd   <= 1'b0;
         bank_wr   <= 1'b0;
         bank_addr <= '0;
         bank_din  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         rsp_err   <= rsp_err_d;
         bank_rd   <= bank_rd_d;
         bank_wr   <= bank_wr_d;
         bank_addr <= bank_addr_d;
         bank_din  <= bank_din_d;
      end
   end

`ifdef MEM_BANK_CTRL_ERR_CNT_EN
   // Counts errored responses at handshake, saturating at 255
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt <= 8'd0;
      end else if (rsp_valid && rsp_ready && rsp_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule : mem_bank_ctrl

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboard bench for mem_bank_ctrl with a behavioural 8x8 bank beside the controller.
module tb_mem_bank_ctrl;
   import mem_bank_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_op;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_data;
   logic [DW-1:0] bank_din;
   logic [AW-1:0] bank_addr;
   logic          bank_wr, bank_rd;
   logic [DW-1:0] bank_dout = '0;
   logic          bank_error = 1'b0;
   logic          err_inject = 1'b0;
`ifdef MEM_BANK_CTRL_ERR_CNT_EN
   logic [7:0]    err_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_bank_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .bank_din(bank_din), .bank_addr(bank_addr), .bank_wr(bank_wr), .bank_rd(bank_rd),
      .bank_dout(bank_dout), .bank_error(bank_error)
`ifdef MEM_BANK_CTRL_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   // Bank: registered read data and error, one cycle after the strobe
   logic [DW-1:0] mem [0:7];
   always @(posedge clk) begin
      if (bank_wr) mem[bank_addr] <= bank_din;
      if (bank_rd) bank_dout <= mem[bank_addr];
      bank_error <= err_inject && (bank_rd || bank_wr);
   end

   typedef struct { logic [DW-1:0] data; logic err; int acc; } rsp_exp_t;
   typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] din; } bank_exp_t;
   rsp_exp_t  rsp_q[$];
   bank_exp_t bank_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: bank strobes and responses against the queued expectations
   logic          prev_act = 1'b0, prev_stall = 1'b0, prev_valid = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_err = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         prev_act = 1'b0; prev_stall = 1'b0; prev_valid = 1'b0;
      end else begin
         check("rd_wr_exclusive", 32'(bank_rd & bank_wr), 0);
         if (bank_rd || bank_wr) begin
            bank_exp_t e;
            check("bank_pulse_width", 32'(prev_act), 0);
            if (bank_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_bank_op actual=rd%0b/wr%0b required=none", bank_rd, bank_wr);
            end else begin
               e = bank_q.pop_front();
               check("bank_op_is_wr", 32'(bank_wr), 32'(e.wr));
               check("bank_addr", 32'(bank_addr), 32'(e.addr));
               if (e.wr) check("bank_din", 32'(bank_din), 32'(e.din));
            end
         end
         prev_act = bank_rd || bank_wr;
         if (req_ready) check("idle_bank_bus_zero", 32'({bank_addr, bank_din}), 0);

         if (rsp_valid) check("resp_quiet", 32'({req_ready, bank_rd, bank_wr}), 0);
         if (prev_stall) begin
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_data", 32'(rsp_data), 32'(prev_data));
            check("stall_err", 32'(rsp_err), 32'(prev_err));
         end
         if (rsp_valid && !prev_valid) begin
            if (rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp actual=valid required=none data=%0h", rsp_data);
            end else begin
               check("rsp_latency", 32'(cyc - rsp_q[0].acc), 3);
            end
         end
         if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
            rsp_exp_t r;
            r = rsp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(r.data));
            check("rsp_err", 32'(rsp_err), 32'(r.err));
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_valid = rsp_valid;
         prev_data  = rsp_data;
         prev_err   = rsp_err;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] xd, input logic xe, input bit keep_valid,
                        input bit expect_rsp, output int acc);
      bank_exp_t be;
      rsp_exp_t  re;
      req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
      for (int i = 0; i < 50 && !req_ready; i++) step();
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=req_ready0 required=req_ready1");
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc;
      be.wr = op; be.addr = a; be.din = d;
      bank_q.push_back(be);
      if (expect_rsp) begin
         re.data = xd; re.err = xe; re.acc = cyc;
         rsp_q.push_back(re);
      end
      step();
      if (!keep_valid) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && !req_ready; i++) step();
      check("idle_reached", 32'(req_ready), 1);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({req_ready, rsp_valid, rsp_data, rsp_err, bank_din, bank_addr, bank_wr, bank_rd});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, prev_acc;
      reset = 1'b1; req_valid = 1'b0; req_op = OP_RD; req_addr = '0; req_data = '0;
      rsp_ready = 1'b1;
      #1;
      check("reset_outputs_zero", all_outs(), 0);
      step(); step();
      check("reset_outputs_held", all_outs(), 0);
      reset = 1'b0;
      #1;
      check("ready_before_edge", 32'(req_ready), 0);
      step();
      check("ready_after_edge", 32'(req_ready), 1);

      // Write then read back the same location
      issue(OP_WR, 3'd3, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, acc);
      wait_idle();
      issue(OP_RD, 3'd3, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, acc);
      wait_idle();

      // Response held while the consumer stalls
      rsp_ready = 1'b0;
      issue(OP_RD, 3'd3, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, acc);
      for (int i = 0; i < 20 && !rsp_valid; i++) step();
      check("stall_rsp_seen", 32'(rsp_valid), 1);
      for (int i = 0; i < 5; i++) step();
      rsp_ready = 1'b1;
      wait_idle();

      // Bank error on a read
      err_inject = 1'b1;
      issue(OP_RD, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, acc);
      wait_idle();
      err_inject = 1'b0;
`ifdef MEM_BANK_CTRL_ERR_CNT_EN
      check("err_cnt_one", 32'(err_cnt), 1);
`endif

      // Reset during WAIT drops the read
      issue(OP_RD, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, acc);
      step();
      reset = 1'b1;
      #1;
      check("mid_reset_outputs_zero", all_outs(), 0);
      step();
      check("mid_reset_outputs_held", all_outs(), 0);
`ifdef MEM_BANK_CTRL_ERR_CNT_EN
      check("err_cnt_cleared", 32'(err_cnt), 0);
`endif
      reset = 1'b0;
      step();
      check("ready_after_mid_reset", 32'(req_ready), 1);
      issue(OP_RD, 3'd3, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, acc);
      wait_idle();

      // Back-to-back writes with req_valid held high
      prev_acc = 0;
      for (int i = 0; i < 8; i++) begin
         issue(OP_WR, 3'(i), 8'(8'h10 + i), 8'h00, 1'b0, 1'b1, 1'b1, acc);
         if (i > 0) check("accept_spacing", 32'(acc - prev_acc), 4);
         prev_acc = acc;
      end
      req_valid = 1'b0;
      wait_idle();
      issue(OP_RD, 3'd7, 8'h00, 8'h17, 1'b0, 1'b0, 1'b1, acc);
      wait_idle();
      issue(OP_RD, 3'd0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, acc);
      wait_idle();

      step(); step();
      check("rsp_queue_drained", 32'(rsp_q.size()), 0);
      check("bank_queue_drained", 32'(bank_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_bank_ctrl

// File: doc/mem_bank_ctrl.md
MEM_BANK_CTRL -- requirements
Module: mem_bank_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning request/response and bank data width.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning bank address width (8 locations).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, request offered.
REQ-006 SHALL have port req_ready, output, 1, controller accepts a request.
REQ-007 SHALL have port req_op, input, 1, 0 = read, 1 = write.
REQ-008 SHALL have port req_addr, input, ADDR_W, target location.
REQ-009 SHALL have port req_data, input, DATA_W, write data (ignored for reads).
REQ-010 SHALL have port rsp_valid, output, 1, response available.
REQ-011 SHALL have port rsp_ready, input, 1, consumer takes the response.
REQ-012 SHALL have port rsp_data, output, DATA_W, read data; 0 for writes.
REQ-013 SHALL have port rsp_err, output, 1, bank flagged an error for this transaction.
REQ-014 SHALL have ports bank_din (DATA_W), bank_addr (ADDR_W), bank_wr (1) and bank_rd (1) as outputs driving the 8x8 bank.
REQ-015 SHALL have ports bank_dout (DATA_W) and bank_error (1) as inputs from the bank.

Function
REQ-016 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-017 SHALL, in IDLE only, drive req_ready=1; on req_valid&&req_ready it captures op/addr/data and goes to ISSUE.
REQ-018 SHALL, in ISSUE, drive exactly one of bank_rd/bank_wr high for one cycle, per the captured op, then go to WAIT.
REQ-019 SHALL never assert bank_rd and bank_wr in the same cycle.
REQ-020 SHALL hold bank_addr and bank_din at the captured values from ISSUE through WAIT; it drives them to 0 in IDLE.
REQ-021 SHALL, in WAIT, sample bank_dout (reads only) and bank_error, since the bank responds one cycle after rd/wr; it then goes to RESP.
REQ-022 SHALL, in RESP, drive rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready, then go to IDLE; rsp_ready outside RESP is ignored.
REQ-023 SHALL drive rsp_data=0 for write responses, regardless of bank_dout.
REQ-024 SHALL derive bank_rd, bank_wr, req_ready and rsp_valid from registered state only, with no combinational path from req_* or rsp_ready.
REQ-025 SHALL give a minimum occupancy of 4 cycles per transaction (accept, ISSUE, WAIT, RESP), with no pipelining or overlap.
REQ-026 SHALL, when bank_error=1 in WAIT, set rsp_err=1 and rsp_data=0.

Reset
REQ-027 SHALL, while reset=1, force the FSM to IDLE and req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0 and all bank_* outputs =0.
REQ-028 SHALL, on reset asserted mid-transaction in any state, drop the captured request with no response issued; req_ready=1 on the first clock edge after deassertion.

Configuration
REQ-029 SHALL, with macro MEM_BANK_CTRL_ERR_CNT_EN defined, add output err_cnt[7:0], which counts responses with rsp_err=1 on handshake, saturates at 255 and is cleared by reset.
REQ-030 SHALL, without MEM_BANK_CTRL_ERR_CNT_EN, omit the err_cnt port and counter entirely.

Structure
REQ-031 SHALL place DATA_W/ADDR_W defaults, the op encoding (OP_RD=0, OP_WR=1) and the FSM state enum in shared package mem_bank_pkg.
REQ-032 SHALL contain no sub-module; the bank is instantiated beside the controller at the next level up.

Verification
REQ-033 SHALL cover: write op=1, addr=3, data=0xA5, rsp_ready=1 -> bank_wr high exactly one cycle with bank_addr=3, bank_din=0xA5; rsp_valid 3 cycles after accept, rsp_data=0, rsp_err=0.
REQ-034 SHALL cover: read addr=3 after the previous write -> bank_rd one cycle; rsp_data=0xA5, rsp_err=0.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0, no bank_rd/bank_wr activity.
REQ-036 SHALL cover: bank model forcing bank_error=1 in WAIT -> rsp_err=1, rsp_data=0; err_cnt=1 when MEM_BANK_CTRL_ERR_CNT_EN is defined.
REQ-037 SHALL cover: reset pulsed during WAIT of a read -> no rsp_valid, all outputs 0; next request completes normally.
REQ-038 SHALL cover: back-to-back req_valid held high for 8 writes to addr 0..7 -> one accept per 4 cycles and bank_rd/bank_wr never both high.
